alu_rs: RTL and testbench

- ALU reservation station: holds dispatched integer ops until both operands are ready, then issues one op per pass to the single-slot ALU.
- Upstream: instruction dispatch (decoder/instruction queue) and the CDB.
- Downstream: ALU, via calc_enable/calc_code/lhs/rhs/pos_in_iq; ALU back-pressure via alu_full_in.
- Uses the core's two-phase update_stat protocol and clear_flag flush.

---
 rtl/alu_rs_if.sv | 50 +++++
 rtl/alu_rs.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_rs.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Bundle of the reservation-station control, dispatch, CDB and ALU-issue signals.
// The master side is the core (dispatcher, CDB, ALU); the slave side is alu_rs.
interface alu_rs_if #(
  parameter int IQ_ADDR_W = 4,
  parameter int CALC_W    = 4
);
  logic                 rdy;
  logic                 update_stat;
  logic                 clear_flag_in;
  logic                 rs_full_out;

  logic                 disp_enable_in;
  logic [CALC_W-1:0]    disp_calc_code_in;
  logic                 disp_lhs_ready_in;
  logic                 disp_rhs_ready_in;
  logic [31:0]          disp_lhs_in;
  logic [31:0]          disp_rhs_in;
  logic [IQ_ADDR_W-1:0] disp_lhs_tag_in;
  logic [IQ_ADDR_W-1:0] disp_rhs_tag_in;
  logic [IQ_ADDR_W-1:0] disp_pos_in_iq_in;

  logic                 cdb_enable_in;
  logic [IQ_ADDR_W-1:0] cdb_tag_in;
  logic [31:0]          cdb_value_in;

  logic                 alu_full_in;
  logic                 alu_calc_enable_out;
  logic [CALC_W-1:0]    alu_calc_code_out;
  logic [31:0]          alu_lhs_out;
  logic [31:0]          alu_rhs_out;
  logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out;

  modport master (
    output rdy, update_stat, clear_flag_in,
    output disp_enable_in, disp_calc_code_in, disp_lhs_ready_in, disp_rhs_ready_in,
    output disp_lhs_in, disp_rhs_in, disp_lhs_tag_in, disp_rhs_tag_in, disp_pos_in_iq_in,
    output cdb_enable_in, cdb_tag_in, cdb_value_in, alu_full_in,
    input  rs_full_out, alu_calc_enable_out, alu_calc_code_out,
    input  alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );

  modport slave (
    input  rdy, update_stat, clear_flag_in,
    input  disp_enable_in, disp_calc_code_in, disp_lhs_ready_in, disp_rhs_ready_in,
    input  disp_lhs_in, disp_rhs_in, disp_lhs_tag_in, disp_rhs_tag_in, disp_pos_in_iq_in,
    input  cdb_enable_in, cdb_tag_in, cdb_value_in, alu_full_in,
    output rs_full_out, alu_calc_enable_out, alu_calc_code_out,
    output alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands are ready, issues one per pass.
// Optional RS_AGE_ORDER_EN: issue the oldest ready entry (age matrix) instead of the lowest index.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int IQ_ADDR_W = 4,
  parameter int CALC_W    = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [RS_SIZE-1:0]   lhs_rdy_q, lhs_rdy_d, rhs_rdy_q, rhs_rdy_d;
  logic [31:0]          lhs_val_q [RS_SIZE];
  logic [31:0]          lhs_val_d [RS_SIZE];
  logic [31:0]          rhs_val_q [RS_SIZE];
  logic [31:0]          rhs_val_d [RS_SIZE];
  logic [IQ_ADDR_W-1:0] lhs_tag_q [RS_SIZE];
  logic [IQ_ADDR_W-1:0] lhs_tag_d [RS_SIZE];
  logic [IQ_ADDR_W-1:0] rhs_tag_q [RS_SIZE];
  logic [IQ_ADDR_W-1:0] rhs_tag_d [RS_SIZE];
  logic [IQ_ADDR_W-1:0] pos_q     [RS_SIZE];
  logic [IQ_ADDR_W-1:0] pos_d     [RS_SIZE];
  logic [CALC_W-1:0]    code_q    [RS_SIZE];
  logic [CALC_W-1:0]    code_d    [RS_SIZE];

  logic                 chip_enable_q, chip_enable_d;
  logic                 calc_en_q, calc_en_d;
  logic [CALC_W-1:0]    calc_code_q, calc_code_d;
  logic [31:0]          lhs_out_q, lhs_out_d, rhs_out_q, rhs_out_d;
  logic [IQ_ADDR_W-1:0] pos_out_q, pos_out_d;

  logic                 full_s, advance_s, flush_s, disp_acc_s, issue_s;
  logic                 disp_l_hit_s, disp_r_hit_s;
  logic [RS_SIZE-1:0]   cand_s, disp_sel_s, wake_l_s, wake_r_s;
  logic [IDX_W-1:0]     free_idx_s, pick_idx_s;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] = 1 means entry i was dispatched before entry j
  logic [RS_SIZE-1:0]   age_q [RS_SIZE];
  logic [RS_SIZE-1:0]   age_d [RS_SIZE];
  logic                 blocked_s;
`endif

  assign bus.rs_full_out         = full_s;
  assign bus.alu_calc_enable_out = calc_en_q;
  assign bus.alu_calc_code_out   = calc_code_q;
  assign bus.alu_lhs_out         = lhs_out_q;
  assign bus.alu_rhs_out         = rhs_out_q;
  assign bus.alu_pos_in_iq_out   = pos_out_q;

  // Free-slot and issue-candidate selection, all from pre-edge state
  always_comb begin
    full_s     = &valid_q;
    cand_s     = valid_q & lhs_rdy_q & rhs_rdy_q;
    free_idx_s = {IDX_W{1'b0}};
    pick_idx_s = {IDX_W{1'b0}};
`ifdef RS_AGE_ORDER_EN
    blocked_s  = 1'b0;
`endif
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = !valid_q[i] ? IDX_W'(i) : free_idx_s;
`ifdef RS_AGE_ORDER_EN
      blocked_s = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) begin
        blocked_s = blocked_s | (cand_s[j] & age_q[j][i]);
      end
      pick_idx_s = (cand_s[i] && !blocked_s) ? IDX_W'(i) : pick_idx_s;
`else
      pick_idx_s = cand_s[i] ? IDX_W'(i) : pick_idx_s;
`endif
    end
  end

  // Next-state for entries and issue outputs: flush > wakeup/dispatch/issue > hold
  always_comb begin
    flush_s       = chip_enable_q & bus.clear_flag_in;
    advance_s     = chip_enable_q & ~bus.update_stat & ~bus.clear_flag_in;
    disp_acc_s    = advance_s & bus.disp_enable_in & ~full_s;
    issue_s       = advance_s & ~bus.alu_full_in & (|cand_s);
    disp_l_hit_s  = ~bus.disp_lhs_ready_in & bus.cdb_enable_in &
                    (bus.disp_lhs_tag_in == bus.cdb_tag_in);
    disp_r_hit_s  = ~bus.disp_rhs_ready_in & bus.cdb_enable_in &
                    (bus.disp_rhs_tag_in == bus.cdb_tag_in);
    chip_enable_d = bus.rdy;
    valid_d       = valid_q;
    lhs_rdy_d     = lhs_rdy_q;
    rhs_rdy_d     = rhs_rdy_q;
    disp_sel_s    = {RS_SIZE{1'b0}};
    wake_l_s      = {RS_SIZE{1'b0}};
    wake_r_s      = {RS_SIZE{1'b0}};
    calc_en_d     = calc_en_q;
    calc_code_d   = calc_code_q;
    lhs_out_d     = lhs_out_q;
    rhs_out_d     = rhs_out_q;
    pos_out_d     = pos_out_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      lhs_val_d[i] = lhs_val_q[i];
      rhs_val_d[i] = rhs_val_q[i];
      lhs_tag_d[i] = lhs_tag_q[i];
      rhs_tag_d[i] = rhs_tag_q[i];
      pos_d[i]     = pos_q[i];
      code_d[i]    = code_q[i];
    end

    for (int i = 0; i < RS_SIZE; i++) begin
      disp_sel_s[i] = disp_acc_s & (free_idx_s == IDX_W'(i));
      wake_l_s[i]   = advance_s & valid_q[i] & ~lhs_rdy_q[i] & bus.cdb_enable_in &
                      (lhs_tag_q[i] == bus.cdb_tag_in);
      wake_r_s[i]   = advance_s & valid_q[i] & ~rhs_rdy_q[i] & bus.cdb_enable_in &
                      (rhs_tag_q[i] == bus.cdb_tag_in);

      if (flush_s) begin
        valid_d[i] = 1'b0;
      end else if (disp_sel_s[i]) begin
        valid_d[i] = 1'b1;
      end else if (issue_s && (pick_idx_s == IDX_W'(i))) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end

      if (disp_sel_s[i]) begin
        lhs_rdy_d[i] = bus.disp_lhs_ready_in | disp_l_hit_s;
        rhs_rdy_d[i] = bus.disp_rhs_ready_in | disp_r_hit_s;
        lhs_val_d[i] = disp_l_hit_s ? bus.cdb_value_in : bus.disp_lhs_in;
        rhs_val_d[i] = disp_r_hit_s ? bus.cdb_value_in : bus.disp_rhs_in;
        lhs_tag_d[i] = bus.disp_lhs_tag_in;
        rhs_tag_d[i] = bus.disp_rhs_tag_in;
        pos_d[i]     = bus.disp_pos_in_iq_in;
        code_d[i]    = bus.disp_calc_code_in;
      end else begin
        lhs_rdy_d[i] = lhs_rdy_q[i] | wake_l_s[i];
        rhs_rdy_d[i] = rhs_rdy_q[i] | wake_r_s[i];
        lhs_val_d[i] = wake_l_s[i] ? bus.cdb_value_in : lhs_val_q[i];
        rhs_val_d[i] = wake_r_s[i] ? bus.cdb_value_in : rhs_val_q[i];
      end
    end

    if (flush_s) begin
      calc_en_d = 1'b0;
    end else if (advance_s) begin
      calc_en_d = issue_s;
    end else begin
      calc_en_d = calc_en_q;
    end

    if (issue_s) begin
      calc_code_d = code_q[pick_idx_s];
      lhs_out_d   = lhs_val_q[pick_idx_s];
      rhs_out_d   = rhs_val_q[pick_idx_s];
      pos_out_d   = pos_q[pick_idx_s];
    end else begin
      calc_code_d = calc_code_q;
      lhs_out_d   = lhs_out_q;
      rhs_out_d   = rhs_out_q;
      pos_out_d   = pos_out_q;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // A newly dispatched entry becomes younger than every other entry
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      age_d[i] = age_q[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (disp_sel_s[i]) begin
          age_d[i][j] = 1'b0;
        end else if (disp_sel_s[j]) begin
          age_d[i][j] = 1'b1;
        end else begin
          age_d[i][j] = age_q[i][j];
        end
      end
    end
  end

  // Age matrix storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      age_q[i] <= age_d[i];
    end
  end
`endif

  // Control state and issue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= {RS_SIZE{1'b0}};
      chip_enable_q <= 1'b0;
      calc_en_q     <= 1'b0;
      calc_code_q   <= {CALC_W{1'b0}};
      lhs_out_q     <= 32'd0;
      rhs_out_q     <= 32'd0;
      pos_out_q     <= {IQ_ADDR_W{1'b0}};
    end else begin
      valid_q       <= valid_d;
      chip_enable_q <= chip_enable_d;
      calc_en_q     <= calc_en_d;
      calc_code_q   <= calc_code_d;
      lhs_out_q     <= lhs_out_d;
      rhs_out_q     <= rhs_out_d;
      pos_out_q     <= pos_out_d;
    end
  end

  // Entry payload; meaningless while the entry is invalid, so not reset
  always_ff @(posedge clk) begin
    lhs_rdy_q <= lhs_rdy_d;
    rhs_rdy_q <= rhs_rdy_d;
    for (int i = 0; i < RS_SIZE; i++) begin
      lhs_val_q[i] <= lhs_val_d[i];
      rhs_val_q[i] <= rhs_val_d[i];
      lhs_tag_q[i] <= lhs_tag_d[i];
      rhs_tag_q[i] <= rhs_tag_d[i];
      pos_q[i]     <= pos_d[i];
      code_q[i]    <= code_d[i];
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized passes against an
// entry-list reference model (issue order by dispatch sequence when RS_AGE_ORDER_EN).
module tb_alu_rs;
  localparam int RS = 8;

  logic clk = 1'b0;
  logic rst;

  alu_rs_if #(.IQ_ADDR_W(4), .CALC_W(4)) bus ();
  alu_rs #(.RS_SIZE(RS), .IQ_ADDR_W(4), .CALC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one record per entry slot plus the expected ALU-side outputs
  bit          m_valid [RS];
  bit          m_lr    [RS];
  bit          m_rr    [RS];
  logic [31:0] m_lv    [RS];
  logic [31:0] m_rv    [RS];
  logic [3:0]  m_lt    [RS];
  logic [3:0]  m_rt    [RS];
  logic [3:0]  m_code  [RS];
  logic [3:0]  m_pos   [RS];
  int          m_seq   [RS];
  int          seq_ctr = 0;
  bit          m_ce    = 1'b0;
  bit          e_en    = 1'b0;
  logic [3:0]  e_code  = 4'd0;
  logic [31:0] e_lhs   = 32'd0;
  logic [31:0] e_rhs   = 32'd0;
  logic [3:0]  e_pos   = 4'd0;

  wire [73:0] obs = {bus.alu_calc_enable_out, bus.alu_calc_code_out, bus.alu_lhs_out,
                     bus.alu_rhs_out, bus.alu_pos_in_iq_out, bus.rs_full_out};

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < RS; i++) f &= m_valid[i];
    return f;
  endfunction

  function automatic logic [73:0] exp_obs();
    return {e_en, e_code, e_lhs, e_rhs, e_pos, model_full()};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
    m_ce = 1'b0; e_en = 1'b0; e_code = 4'd0; e_lhs = 32'd0; e_rhs = 32'd0; e_pos = 4'd0;
  endtask

  task automatic model_step(input bit phase1);
    bit full;
    int pick;
    int slot;
    if (!m_ce) return;
    if (bus.clear_flag_in) begin
      for (int i = 0; i < RS; i++) m_valid[i] = 1'b0;
      e_en = 1'b0;
      return;
    end
    if (phase1) return;
    full = model_full();
    pick = -1;
    for (int i = 0; i < RS; i++) begin
      if (m_valid[i] && m_lr[i] && m_rr[i]) begin
`ifdef RS_AGE_ORDER_EN
        if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    if (bus.cdb_enable_in) begin
      for (int i = 0; i < RS; i++) begin
        if (m_valid[i] && !m_lr[i] && m_lt[i] == bus.cdb_tag_in) begin
          m_lr[i] = 1'b1; m_lv[i] = bus.cdb_value_in;
        end
        if (m_valid[i] && !m_rr[i] && m_rt[i] == bus.cdb_tag_in) begin
          m_rr[i] = 1'b1; m_rv[i] = bus.cdb_value_in;
        end
      end
    end
    if (bus.disp_enable_in && !full) begin
      slot = -1;
      for (int i = RS - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      m_valid[slot] = 1'b1;
      m_code[slot]  = bus.disp_calc_code_in;
      m_pos[slot]   = bus.disp_pos_in_iq_in;
      m_lt[slot]    = bus.disp_lhs_tag_in;
      m_rt[slot]    = bus.disp_rhs_tag_in;
      m_lr[slot]    = bus.disp_lhs_ready_in;
      m_rr[slot]    = bus.disp_rhs_ready_in;
      m_lv[slot]    = bus.disp_lhs_in;
      m_rv[slot]    = bus.disp_rhs_in;
      if (!m_lr[slot] && bus.cdb_enable_in && m_lt[slot] == bus.cdb_tag_in) begin
        m_lr[slot] = 1'b1; m_lv[slot] = bus.cdb_value_in;
      end
      if (!m_rr[slot] && bus.cdb_enable_in && m_rt[slot] == bus.cdb_tag_in) begin
        m_rr[slot] = 1'b1; m_rv[slot] = bus.cdb_value_in;
      end
      m_seq[slot] = seq_ctr;
      seq_ctr++;
    end
    if (!bus.alu_full_in && pick >= 0) begin
      e_en = 1'b1; e_code = m_code[pick]; e_lhs = m_lv[pick]; e_rhs = m_rv[pick];
      e_pos = m_pos[pick];
      m_valid[pick] = 1'b0;
    end else begin
      e_en = 1'b0;
    end
  endtask

  task automatic set_disp(input logic [3:0] code, input bit lr, input logic [31:0] lv,
                          input logic [3:0] lt, input bit rr, input logic [31:0] rv,
                          input logic [3:0] rt, input logic [3:0] pos);
    bus.disp_enable_in = 1'b1; bus.disp_calc_code_in = code;
    bus.disp_lhs_ready_in = lr; bus.disp_lhs_in = lv; bus.disp_lhs_tag_in = lt;
    bus.disp_rhs_ready_in = rr; bus.disp_rhs_in = rv; bus.disp_rhs_tag_in = rt;
    bus.disp_pos_in_iq_in = pos;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_enable_in = 1'b1; bus.cdb_tag_in = tag; bus.cdb_value_in = val;
  endtask

  task automatic phase0();
    bus.update_stat = 1'b0;
    model_step(1'b0);
    m_ce = bus.rdy;
    @(posedge clk); #1;
    bus.disp_enable_in = 1'b0; bus.cdb_enable_in = 1'b0; bus.clear_flag_in = 1'b0;
  endtask

  task automatic phase1(input bit clr);
    bus.update_stat = 1'b1; bus.disp_enable_in = 1'b0; bus.cdb_enable_in = 1'b0;
    bus.clear_flag_in = clr;
    model_step(1'b1);
    m_ce = bus.rdy;
    @(posedge clk); #1;
    bus.clear_flag_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.rdy = 1'b1; bus.update_stat = 1'b1; bus.clear_flag_in = 1'b0;
    bus.disp_enable_in = 1'b0; bus.cdb_enable_in = 1'b0; bus.alu_full_in = 1'b0;
    set_disp(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    bus.disp_enable_in = 1'b0;
    set_cdb(4'd0, 32'd0);
    bus.cdb_enable_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 74'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(posedge clk); #1;
    rst = 1'b1;
    phase1(1'b0);
    checks++;
    if (obs !== exp_obs()) begin errors++; $display("FAIL reset_release: got %h want %h", obs, exp_obs()); end
  endtask

  task automatic test_basic_issue();
    bus.alu_full_in = 1'b0;
    set_disp(4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    phase0();
    checks++;
    if (obs !== exp_obs() || bus.alu_calc_enable_out !== 1'b0) begin
      errors++; $display("FAIL basic_no_early_issue: got %h want %h", obs, exp_obs());
    end
    phase1(1'b0);
    phase0();
    checks++;
    if (obs !== {1'b1, 4'd0, 32'd5, 32'd7, 4'd3, 1'b0}) begin
      errors++; $display("FAIL basic_issue: got %h want en=1 code=0 lhs=5 rhs=7 pos=3", obs);
    end
    phase1(1'b0);
    checks++;
    if (obs !== {1'b1, 4'd0, 32'd5, 32'd7, 4'd3, 1'b0}) begin
      errors++; $display("FAIL basic_hold_phase1: got %h", obs);
    end
    phase0();
    checks++;
    if (obs !== {1'b0, 4'd0, 32'd5, 32'd7, 4'd3, 1'b0}) begin
      errors++; $display("FAIL basic_single_pulse: got %h want en=0 data held", obs);
    end
    phase1(1'b0);
  endtask

  task automatic test_wakeup();
    set_disp(4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 32'hDEAD, 4'd2, 4'd4);
    phase0(); phase1(1'b0);
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0 || obs !== exp_obs()) begin
      errors++; $display("FAIL wakeup_waits: got %h want %h", obs, exp_obs());
    end
    phase1(1'b0);
    set_cdb(4'd2, 32'h10);
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0) begin
      errors++; $display("FAIL wakeup_same_pass: got en=%b want 0", bus.alu_calc_enable_out);
    end
    phase1(1'b0);
    phase0();
    checks++;
    if (obs !== {1'b1, 4'd2, 32'd1, 32'h10, 4'd4, 1'b0}) begin
      errors++; $display("FAIL wakeup_issue: got %h want en=1 code=2 lhs=1 rhs=10 pos=4", obs);
    end
    phase1(1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < RS; i++) begin
      set_disp(4'(i), 1'b1, 32'(i), 4'd0, 1'b0, 32'd0, 4'(i), 4'(i));
      phase0(); phase1(1'b0);
    end
    checks++;
    if (bus.rs_full_out !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", bus.rs_full_out); end
    set_disp(4'd9, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd9);
    phase0(); phase1(1'b0);
    checks++;
    if (obs !== exp_obs() || bus.rs_full_out !== 1'b1) begin
      errors++; $display("FAIL full_drop: got %h want %h", obs, exp_obs());
    end
    set_cdb(4'd0, 32'hAA);
    phase0(); phase1(1'b0);
    set_disp(4'd10, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd10);
    phase0();
    checks++;
    if (obs !== {1'b1, 4'd0, 32'd0, 32'hAA, 4'd0, 1'b0}) begin
      errors++; $display("FAIL full_issue_refuse: got %h want en=1 rhs=aa pos=0 full=0", obs);
    end
    phase1(1'b0);
  endtask

  task automatic test_alu_full();
    bus.clear_flag_in = 1'b1;
    phase0(); phase1(1'b0);
    bus.alu_full_in = 1'b1;
    set_disp(4'd5, 1'b1, 32'd50, 4'd0, 1'b1, 32'd51, 4'd0, 4'd5);
    phase0(); phase1(1'b0);
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0) begin
      errors++; $display("FAIL alu_full_stall: got en=%b want 0", bus.alu_calc_enable_out);
    end
    phase1(1'b0);
    bus.alu_full_in = 1'b0;
    phase0();
    checks++;
    if (obs !== {1'b1, 4'd5, 32'd50, 32'd51, 4'd5, 1'b0}) begin
      errors++; $display("FAIL alu_full_release: got %h want en=1 pos=5", obs);
    end
    phase1(1'b0);
  endtask

  task automatic test_flush();
    bus.alu_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_disp(4'(i), 1'b1, 32'(i), 4'd0, (i == 2), 32'd3, 4'd15, 4'(i));
      phase0(); phase1(1'b0);
    end
    bus.alu_full_in = 1'b0;
    bus.clear_flag_in = 1'b1;
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b0 || obs !== exp_obs()) begin
      errors++; $display("FAIL flush_phase0: got %h want %h", obs, exp_obs());
    end
    phase1(1'b0);
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0) begin
      errors++; $display("FAIL flush_no_issue: got en=%b want 0", bus.alu_calc_enable_out);
    end
    phase1(1'b0);
    set_disp(4'd7, 1'b1, 32'd70, 4'd0, 1'b1, 32'd71, 4'd0, 4'd7);
    phase0(); phase1(1'b0);
    phase0();
    phase1(1'b1);
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0 || obs !== exp_obs()) begin
      errors++; $display("FAIL flush_phase1: got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_chip_enable();
    bus.rdy = 1'b0;
    phase1(1'b0);
    set_disp(4'd6, 1'b1, 32'd60, 4'd0, 1'b1, 32'd61, 4'd0, 4'd6);
    phase0();
    checks++;
    if (obs !== exp_obs()) begin errors++; $display("FAIL ce_hold: got %h want %h", obs, exp_obs()); end
    phase1(1'b0);
    bus.rdy = 1'b1;
    phase1(1'b0);
    phase0();
    checks++;
    if (bus.alu_calc_enable_out !== 1'b0 || bus.rs_full_out !== 1'b0) begin
      errors++; $display("FAIL ce_dispatch_ignored: got en=%b full=%b want 0 0",
                         bus.alu_calc_enable_out, bus.rs_full_out);
    end
    phase1(1'b0);
  endtask

  task automatic test_age_order();
    bus.clear_flag_in = 1'b1;
    phase0(); phase1(1'b0);
    bus.alu_full_in = 1'b1;
    set_disp(4'd1, 1'b1, 32'd11, 4'd0, 1'b0, 32'd0, 4'd9, 4'd1);
    phase0(); phase1(1'b0);
    set_disp(4'd2, 1'b1, 32'd22, 4'd0, 1'b1, 32'd23, 4'd0, 4'd2);
    phase0(); phase1(1'b0);
    set_cdb(4'd9, 32'h99);
    phase0(); phase1(1'b0);
    bus.alu_full_in = 1'b0;
    phase0();
    checks++;
    if (obs !== {1'b1, 4'd1, 32'd11, 32'h99, 4'd1, 1'b0}) begin
      errors++; $display("FAIL age_first: got %h want pos=1 rhs=99", obs);
    end
    phase1(1'b0);
    bus.alu_full_in = 1'b1;
    set_disp(4'd3, 1'b1, 32'd33, 4'd0, 1'b1, 32'd34, 4'd0, 4'd3);
    phase0(); phase1(1'b0);
    bus.alu_full_in = 1'b0;
    phase0();
    checks++;
`ifdef RS_AGE_ORDER_EN
    if (obs !== {1'b1, 4'd2, 32'd22, 32'd23, 4'd2, 1'b0}) begin
      errors++; $display("FAIL age_second: got %h want oldest pos=2", obs);
    end
`else
    if (obs !== {1'b1, 4'd3, 32'd33, 32'd34, 4'd3, 1'b0}) begin
      errors++; $display("FAIL index_second: got %h want lowest-index pos=3", obs);
    end
`endif
    phase1(1'b0);
    phase0();
    checks++;
    if (obs !== exp_obs() || bus.alu_calc_enable_out !== 1'b1) begin
      errors++; $display("FAIL order_third: got %h want %h", obs, exp_obs());
    end
    phase1(1'b0);
  endtask

  task automatic test_async_reset();
    bus.alu_full_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_disp(4'd4, 1'b1, 32'd40, 4'd0, 1'b1, 32'd41, 4'd0, 4'(i));
      phase0(); phase1(1'b0);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 74'd0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
    @(posedge clk); #1;
    rst = 1'b1;
    phase1(1'b0);
    bus.alu_full_in = 1'b0;
    phase0();
    checks++;
    if (obs !== 74'd0 || obs !== exp_obs()) begin
      errors++; $display("FAIL reset_resume_empty: got %h want 0", obs);
    end
    phase1(1'b0);
  endtask

  task automatic test_random();
    bus.clear_flag_in = 1'b1;
    phase0(); phase1(1'b0);
    for (int n = 0; n < 300; n++) begin
      bus.alu_full_in = ($urandom_range(0, 3) == 0);
      if (!model_full() && $urandom_range(0, 2) != 0) begin
        set_disp(4'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 7)),
                 1'($urandom), $urandom, 4'($urandom_range(0, 7)), 4'($urandom));
      end
      if ($urandom_range(0, 1) == 1) set_cdb(4'($urandom_range(0, 7)), $urandom);
      bus.clear_flag_in = ($urandom_range(0, 59) == 0);
      phase0();
      checks++;
      if (obs !== exp_obs()) begin
        errors++; $display("FAIL random_phase0[%0d]: got %h want %h", n, obs, exp_obs());
      end
      phase1($urandom_range(0, 79) == 0);
      checks++;
      if (obs !== exp_obs()) begin
        errors++; $display("FAIL random_phase1[%0d]: got %h want %h", n, obs, exp_obs());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_alu_full();
    test_flush();
    test_chip_enable();
    test_age_order();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
